// File: rtl/bcd_digit_packer_if.sv
// Stream bundle for the BCD digit packer: digit input stream and packed frame output.
interface bcd_digit_packer_if #(
  parameter int DIGITS = 300,
  parameter int CW     = 9
);
  logic [3:0]          in_digit;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;
  logic                bcd_ready;
  logic [CW-1:0]       frame_len;
  logic [CW-1:0]       bad_count;

  modport master (
    output in_digit, in_valid, in_last, bcd_ready,
    input  in_ready, bcd, bcd_valid, frame_len, bad_count
  );

  modport slave (
    input  in_digit, in_valid, in_last, bcd_ready,
    output in_ready, bcd, bcd_valid, frame_len, bad_count
  );
endinterface

// File: rtl/bcd_digit_packer.sv
// Packs BCD digits LSD-first into a DIGITS-slot frame and hands the frame downstream.
//
// state | meaning
// FILL  | accepting digits into the frame register
// FULL  | frame presented on bcd, waiting for bcd_ready
module bcd_digit_packer #(
  parameter int DIGITS = 300,
  parameter int CW     = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  bcd_digit_packer_if.slave  bus
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       idx_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [CW-1:0]       len_q;
  logic [CW-1:0]       bad_q;
  logic                accept;
  logic                frame_end;
  logic                handshake;
  logic                in_ready_c;
  logic                bcd_valid_c;

  assign accept    = bus.in_valid && (state_q == FILL);
  assign frame_end = bus.in_last || (idx_q == CW'(DIGITS - 1));
  assign handshake = (state_q == FULL) && bus.bcd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && frame_end) state_d = FULL;
      FULL:    if (bus.bcd_ready)       state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    bcd_valid_c = 1'b0;
    case (state_q)
      FILL:    in_ready_c  = 1'b1;
      FULL:    bcd_valid_c = 1'b1;
      default: in_ready_c  = 1'b1;
    endcase
  end

  // Frame register is cleared on handoff so short frames read zero in unused slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      bcd_q <= '0;
      len_q <= '0;
      bad_q <= '0;
    end else if (accept) begin
      bcd_q[{idx_q, 2'b00} +: 4] <= bus.in_digit;
      bad_q <= bad_q + CW'(bus.in_digit > 4'd9);
      len_q <= idx_q + 1'b1;
      idx_q <= frame_end ? '0 : idx_q + 1'b1;
    end else if (handshake) begin
      bcd_q <= '0;
      len_q <= '0;
      bad_q <= '0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.bcd_valid = bcd_valid_c;
  assign bus.bcd       = bcd_q;
  assign bus.frame_len = len_q;
  assign bus.bad_count = bad_q;

endmodule

// File: tb/tb_bcd_digit_packer.sv
// Directed bench for bcd_digit_packer: full, short, non-BCD, backpressure, bubbles, reset.
module tb_bcd_digit_packer;
  localparam int DIGITS = 300;
  localparam int CW     = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] exp_nib [DIGITS];

  bcd_digit_packer_if #(.DIGITS(DIGITS), .CW(CW)) bus ();

  bcd_digit_packer #(.DIGITS(DIGITS), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [3:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_digit = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_frame(input int len);
    for (int k = 0; k < DIGITS; k++)
      chk($sformatf("nib%0d", k), 64'(bus.bcd[4*k +: 4]), (k < len) ? 64'(exp_nib[k]) : 64'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_digit  = 4'd0;
    bus.in_last   = 1'b0;
    bus.bcd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bcd_valid", 64'(bus.bcd_valid), 64'd0);
    chk("rst_bcd", 64'(|bus.bcd), 64'd0);
    chk("rst_len", 64'(bus.frame_len), 64'd0);
    chk("rst_bad", 64'(bus.bad_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // full frame, bcd_ready held high
    bus.bcd_ready = 1'b1;
    for (int k = 0; k < DIGITS; k++) exp_nib[k] = 4'(k % 10);
    for (int k = 0; k < DIGITS - 1; k++) send(4'(k % 10), 1'b0);
    chk("full_pre_valid", 64'(bus.bcd_valid), 64'd0);
    send(4'd9, 1'b0);
    chk("full_valid", 64'(bus.bcd_valid), 64'd1);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    check_frame(DIGITS);
    chk("full_len", 64'(bus.frame_len), 64'd300);
    chk("full_bad", 64'(bus.bad_count), 64'd0);
    @(negedge clk);
    chk("full_hs_valid", 64'(bus.bcd_valid), 64'd0);
    chk("full_hs_ready", 64'(bus.in_ready), 64'd1);
    chk("full_hs_bcd", 64'(|bus.bcd), 64'd0);
    chk("full_hs_len", 64'(bus.frame_len), 64'd0);
    bus.bcd_ready = 1'b0;

    // short frame 1..5
    for (int k = 1; k <= 5; k++) send(4'(k), k == 5);
    chk("short_valid", 64'(bus.bcd_valid), 64'd1);
    chk("short_low", 64'(bus.bcd[19:0]), 64'h54321);
    chk("short_high", 64'(|bus.bcd[4*DIGITS-1:20]), 64'd0);
    chk("short_len", 64'(bus.frame_len), 64'd5);
    bus.bcd_ready = 1'b1;
    @(negedge clk);
    bus.bcd_ready = 1'b0;
    chk("short_hs_valid", 64'(bus.bcd_valid), 64'd0);

    // non-BCD digits at slots 2, 5, 9
    begin
      logic [3:0] v [10];
      v = '{4'h0, 4'h1, 4'hA, 4'h3, 4'h4, 4'hF, 4'h6, 4'h7, 4'h8, 4'hC};
      for (int k = 0; k < 10; k++) send(v[k], k == 9);
    end
    chk("bad_word", 64'(bus.bcd[39:0]), 64'hC876F43A10);
    chk("bad_nib2", 64'(bus.bcd[11:8]), 64'hA);
    chk("bad_count", 64'(bus.bad_count), 64'd3);
    chk("bad_len", 64'(bus.frame_len), 64'd10);

    // backpressure with digits offered
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_digit = 4'(i);
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_bcd", 64'(bus.bcd[63:0]), 64'hC876F43A10);
      chk("bp_len", 64'(bus.frame_len), 64'd10);
      chk("bp_bad", 64'(bus.bad_count), 64'd3);
    end
    chk("bp_valid", 64'(bus.bcd_valid), 64'd1);
    bus.in_valid  = 1'b0;
    bus.bcd_ready = 1'b1;
    @(negedge clk);
    bus.bcd_ready = 1'b0;
    chk("bp_rel_valid", 64'(bus.bcd_valid), 64'd0);
    chk("bp_rel_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_rel_bcd", 64'(|bus.bcd), 64'd0);
    chk("bp_rel_bad", 64'(bus.bad_count), 64'd0);
    send(4'd6, 1'b1);
    chk("bp_next_slot0", 64'(bus.bcd[7:0]), 64'h06);
    chk("bp_next_len", 64'(bus.frame_len), 64'd1);
    bus.bcd_ready = 1'b1;
    @(negedge clk);
    bus.bcd_ready = 1'b0;

    // full frame with random bubbles
    for (int k = 0; k < DIGITS; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(4'(k % 10), 1'b0);
    end
    chk("bub_valid", 64'(bus.bcd_valid), 64'd1);
    check_frame(DIGITS);
    chk("bub_len", 64'(bus.frame_len), 64'd300);
    chk("bub_bad", 64'(bus.bad_count), 64'd0);
    bus.bcd_ready = 1'b1;
    @(negedge clk);
    bus.bcd_ready = 1'b0;

    // reset in the middle of a frame
    for (int k = 0; k < 100; k++) send(4'(k % 16), 1'b0);
    chk("mid_len", 64'(bus.frame_len), 64'd100);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_bcd", 64'(|bus.bcd), 64'd0);
    chk("mid_rst_len", 64'(bus.frame_len), 64'd0);
    chk("mid_rst_bad", 64'(bus.bad_count), 64'd0);
    chk("mid_rst_valid", 64'(bus.bcd_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rel_ready", 64'(bus.in_ready), 64'd1);
    send(4'd7, 1'b0);
    send(4'd8, 1'b0);
    send(4'd9, 1'b1);
    chk("post_valid", 64'(bus.bcd_valid), 64'd1);
    chk("post_bcd", 64'(bus.bcd[11:0]), 64'h987);
    chk("post_high", 64'(|bus.bcd[4*DIGITS-1:12]), 64'd0);
    chk("post_len", 64'(bus.frame_len), 64'd3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/bcd_digit_packer.md
# bcd_digit_packer

Upstream feeder for the 300-digit BCD-to-decimal stage. It accepts BCD digits one per cycle over a valid/ready stream, packs them least-significant digit first into a 1200-bit frame register, and presents the completed frame on `bcd` with a valid/ready output handshake. It also reports the frame length and how many packed digits are non-BCD (>9), so the downstream clean-up can be monitored.

## Interface
- `DIGITS`, 300, number of 4-bit digit slots per frame; output width is 4*DIGITS.
- `CW`, 9, counter width; must satisfy 2^CW > DIGITS.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_digit`  in  4  incoming BCD digit; values 10–15 are accepted and packed unchanged.
- `in_valid`  in  1  `in_digit`/`in_last` are valid.
- `in_last`  in  1  this digit ends the frame early; qualified by `in_valid`.
- `in_ready`  out  1  packer can accept a digit this cycle.
- `bcd`  out  4*DIGITS  packed frame; slot k occupies bits [4k+3:4k].
- `bcd_valid`  out  1  frame in `bcd` is complete and stable.
- `bcd_ready`  in  1  downstream accepts the frame.
- `frame_len`  out  CW  number of digits in the presented frame, 1..DIGITS.
- `bad_count`  out  CW  number of digits >9 in the presented frame.

## Operation
- Two states: FILL and FULL. In FILL, `in_ready`=1 and `bcd_valid`=0. In FULL, `in_ready`=0 and `bcd_valid`=1. Both outputs decode directly from the state register.
- A digit is accepted when `in_valid && in_ready`. On accept:
  - `in_digit` is written to slot `idx`, and `idx` increments.
  - `bad_count` increments if `in_digit` > 9.
  - `frame_len` is set to `idx`+1.
- FILL→FULL happens on the accept of slot DIGITS-1 or on any accept with `in_last`=1. `idx` then returns to 0.
- `in_last` on slot DIGITS-1 behaves the same as a normal full frame.
- Unwritten slots of a short frame read 0.
- FULL→FILL happens on `bcd_valid && bcd_ready`. On that edge:
  - `bcd` clears to 0.
  - `frame_len` and `bad_count` clear to 0.
- `in_valid` is ignored in FULL. Upstream must hold its digit until `in_ready` is high.
- `bcd_ready` is ignored in FILL.
- `bcd`, `frame_len` and `bad_count` do not change while `bcd_valid`=1.
- No digit is dropped or duplicated. Bubbles on `in_valid` do not advance `idx`.
- Reset (`reset_n`=0, asynchronous) forces:
  - state FILL, `idx`=0;
  - `bcd`=0, `frame_len`=0, `bad_count`=0;
  - `bcd_valid`=0, `in_ready`=1 once reset is released.
- A partial frame in progress at reset is discarded. A presented frame at reset is discarded.

## Timing
- Input throughput: one digit per cycle while in FILL.
- Latency: last digit accepted at edge N; `bcd_valid`=1 and `bcd` complete after edge N, i.e. in cycle N+1.
- Frame handshake at edge M: `bcd_valid`=0 and `in_ready`=1 from cycle M+1. The first digit of the next frame can be accepted at edge M+1.
- Turnaround cost is one cycle per frame: a full frame takes ≥ DIGITS+1 cycles back-to-back with `bcd_ready` tied high.
- There is no combinational path from `in_valid`/`bcd_ready` to `in_ready`/`bcd_valid`.
- Reset assertion takes effect immediately, independent of `clk`. Deassertion is expected to be synchronous to `clk` (externally synchronized).

## Test plan
- Full frame: 300 digits, slot k = k mod 10, no bubbles, `bcd_ready`=1.
  - `bcd_valid` rises the cycle after the 300th accept.
  - Every nibble k equals k mod 10; `frame_len`=300, `bad_count`=0.
  - `in_ready` returns one cycle after the handshake.
- Short frame: digits 1,2,3,4,5 with `in_last` on the 5th.
  - `bcd[19:0]`=0x54321 and all higher bits 0.
  - `frame_len`=5.
- Invalid digits: 10-digit frame containing 0xA, 0xF, 0xC at slots 2, 5, 9, with `in_last` on slot 9.
  - Those nibbles are packed raw.
  - `bad_count`=3, `frame_len`=10.
- Backpressure: complete a frame, hold `bcd_ready`=0 for 20 cycles with `in_valid`=1 and changing digits.
  - `in_ready` stays 0; `bcd`, `frame_len` and `bad_count` stay constant.
  - After releasing `bcd_ready`, `bcd` reads 0 and `in_ready`=1 the next cycle.
  - The next frame starts at slot 0.
- Bubbles: random `in_valid` gaps during a 300-digit frame. The packed result is identical to the gap-free case.
- Reset mid-frame: assert `reset_n`=0 between clock edges after 100 digits.
  - All outputs go to 0 immediately.
  - After release, a 3-digit frame 7,8,9 with `in_last` yields `bcd[11:0]`=0x987 and `frame_len`=3.
